// File: rtl/renderer_rect_line_seq.sv
// Rectangle line sequencer: accepts one rectangle command, clips it to the
// screen and drives the rectangle-mix stage one scanline at a time.
module renderer_rect_line_seq #(
  parameter int unsigned H_RES = 640,
  parameter int unsigned V_RES = 480
) (
  input  logic       i_master_clk,
  input  logic       i_reset_n,
  input  logic       i_cmd_valid,
  output logic       o_cmd_ready,
  input  logic [9:0] i_cmd_x1,
  input  logic [9:0] i_cmd_x2,
  input  logic [9:0] i_cmd_y1,
  input  logic [9:0] i_cmd_y2,
  input  logic       i_buffer_bank,
  output logic       o_cmd_done,
  output logic       o_cmd_rejected,
  output logic       o_busy,
  output logic [9:0] o_cmd_coord_x1,
  output logic [9:0] o_cmd_coord_x2,
  output logic [9:0] o_line_address,
  output logic       o_buffer_bank,
  output logic       o_process_start,
  input  logic       i_process_done
);

  localparam int unsigned CW = 10;
  // Last on-screen column / line; comparing with '>' against these avoids
  // mixing the 10-bit coordinates with the 32-bit resolution parameters.
  localparam logic [CW-1:0] X_MAX = CW'(H_RES - 1);
  localparam logic [CW-1:0] Y_MAX = CW'(V_RES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_START,
    S_WAIT,
    S_NEXT,
    S_DONE
  } state_t;

  state_t        state;
  logic [CW-1:0] y1_q;
  logic [CW-1:0] y2_q;
  logic          reject_c;

  // Discard commands that are inverted or start off-screen.
  assign reject_c = (o_cmd_coord_x1 > o_cmd_coord_x2) ||
                    (y1_q > y2_q) ||
                    (o_cmd_coord_x1 > X_MAX) ||
                    (y1_q > Y_MAX);

  // Sequencer FSM; every output is a flop, pulses are set on entry to the
  // state that owns them so they are glitch-free one-cycle strobes.
  always_ff @(posedge i_master_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state           <= S_IDLE;
      o_cmd_ready     <= 1'b1;
      o_cmd_done      <= 1'b0;
      o_cmd_rejected  <= 1'b0;
      o_busy          <= 1'b0;
      o_cmd_coord_x1  <= '0;
      o_cmd_coord_x2  <= '0;
      o_line_address  <= '0;
      o_buffer_bank   <= 1'b0;
      o_process_start <= 1'b0;
      y1_q            <= '0;
      y2_q            <= '0;
    end else begin
      o_process_start <= 1'b0;
      o_cmd_done      <= 1'b0;
      o_cmd_rejected  <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (i_cmd_valid && o_cmd_ready) begin
            o_cmd_coord_x1 <= i_cmd_x1;
            o_cmd_coord_x2 <= i_cmd_x2;
            y1_q           <= i_cmd_y1;
            y2_q           <= i_cmd_y2;
            o_buffer_bank  <= i_buffer_bank;
            o_cmd_ready    <= 1'b0;
            o_busy         <= 1'b1;
            state          <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (reject_c) begin
            o_cmd_done     <= 1'b1;
            o_cmd_rejected <= 1'b1;
            state          <= S_DONE;
          end else begin
            if (o_cmd_coord_x2 > X_MAX) o_cmd_coord_x2 <= X_MAX;
            if (y2_q > Y_MAX)           y2_q           <= Y_MAX;
            o_line_address  <= y1_q;
            o_process_start <= 1'b1;
            state           <= S_START;
          end
        end
        S_START: begin
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (i_process_done) state <= S_NEXT;
        end
        S_NEXT: begin
          // y2_q is already clamped, so the increment never wraps.
          if (o_line_address == y2_q) begin
            o_cmd_done <= 1'b1;
            state      <= S_DONE;
          end else begin
            o_line_address  <= o_line_address + CW'(1);
            o_process_start <= 1'b1;
            state           <= S_START;
          end
        end
        S_DONE: begin
          o_cmd_ready <= 1'b1;
          o_busy      <= 1'b0;
          state       <= S_IDLE;
        end
        default: begin
          o_cmd_ready <= 1'b1;
          o_busy      <= 1'b0;
          state       <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_renderer_rect_line_seq.sv
// Scoreboard bench for the rectangle line sequencer with a mix-stage model.
module tb_renderer_rect_line_seq;

  localparam int MIX_DELAY = 8;

  typedef struct packed {
    logic [9:0] line;
    logic [9:0] x1;
    logic [9:0] x2;
    logic       bank;
  } start_t;

  logic       i_master_clk;
  logic       i_reset_n;
  logic       i_cmd_valid;
  logic       o_cmd_ready;
  logic [9:0] i_cmd_x1, i_cmd_x2, i_cmd_y1, i_cmd_y2;
  logic       i_buffer_bank;
  logic       o_cmd_done, o_cmd_rejected, o_busy;
  logic [9:0] o_cmd_coord_x1, o_cmd_coord_x2, o_line_address;
  logic       o_buffer_bank, o_process_start, i_process_done;

  renderer_rect_line_seq dut (
    .i_master_clk    (i_master_clk),
    .i_reset_n       (i_reset_n),
    .i_cmd_valid     (i_cmd_valid),
    .o_cmd_ready     (o_cmd_ready),
    .i_cmd_x1        (i_cmd_x1),
    .i_cmd_x2        (i_cmd_x2),
    .i_cmd_y1        (i_cmd_y1),
    .i_cmd_y2        (i_cmd_y2),
    .i_buffer_bank   (i_buffer_bank),
    .o_cmd_done      (o_cmd_done),
    .o_cmd_rejected  (o_cmd_rejected),
    .o_busy          (o_busy),
    .o_cmd_coord_x1  (o_cmd_coord_x1),
    .o_cmd_coord_x2  (o_cmd_coord_x2),
    .o_line_address  (o_line_address),
    .o_buffer_bank   (o_buffer_bank),
    .o_process_start (o_process_start),
    .i_process_done  (i_process_done)
  );

  initial begin
    i_master_clk = 1'b0;
    forever #5 i_master_clk = ~i_master_clk;
  end

  int     n_checks = 0;
  int     n_errors = 0;
  int     cyc = 0;
  int     starts = 0;
  int     dones = 0;
  int     cd = 0;
  int     done_cyc = 0;
  int     acc_cyc = 0;
  int     s0 = 0;
  int     d0 = 0;
  int     exp_lines = 0;
  bit     fired = 0;
  bit     last_fired = 0;
  bit     toggle_bank = 0;
  start_t cur;
  start_t exp_q[$];
  bit     done_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: sample at the falling edge, run the mix-stage model and scoreboard.
  task automatic tick();
    start_t e;
    @(negedge i_master_clk);
    cyc++;
    last_fired = fired;
    fired = 0;
    i_process_done = 1'b0;
    if (toggle_bank) i_buffer_bank = ~i_buffer_bank;
    if (!i_reset_n) cd = 0;
    if (cd != 0) begin
      check("line_hold", o_line_address, cur.line);
      check("x2_hold", o_cmd_coord_x2, cur.x2);
      cd--;
      if (cd == 0) begin
        i_process_done = 1'b1;
        fired = 1;
      end
    end
    if (o_process_start) begin
      starts++;
      check("busy_at_start", o_busy, 1);
      if (exp_q.size() == 0) begin
        check("unexpected_start", 1, 0);
      end else begin
        e = exp_q.pop_front();
        cur = e;
        check("line", o_line_address, e.line);
        check("x1", o_cmd_coord_x1, e.x1);
        check("x2", o_cmd_coord_x2, e.x2);
        check("bank", o_buffer_bank, e.bank);
      end
      cd = MIX_DELAY;
    end
    check("ready_vs_busy", o_cmd_ready, !o_busy);
    if (o_cmd_done) begin
      dones++;
      done_cyc = cyc;
      check("busy_at_done", o_busy, 1);
      if (done_q.size() == 0) check("unexpected_done", 1, 0);
      else check("rejected", o_cmd_rejected, done_q.pop_front());
    end else if (o_cmd_rejected) begin
      check("rejected_without_done", 1, 0);
    end
  endtask

  // Accept one command, push its expected results and check first-response latency.
  task automatic issue(input logic [9:0] x1, input logic [9:0] x2, input logic [9:0] y1,
                       input logic [9:0] y2, input logic bank, input bit spur);
    int  n;
    bit  rej;
    logic [9:0] x2c, y2c;
    start_t e;
    n = 0;
    while (!o_cmd_ready && n < 100) begin
      tick();
      n++;
    end
    if (!o_cmd_ready) check("ready_timeout", 0, 1);
    i_cmd_valid   = 1'b1;
    i_cmd_x1      = x1;
    i_cmd_x2      = x2;
    i_cmd_y1      = y1;
    i_cmd_y2      = y2;
    i_buffer_bank = bank;
    acc_cyc = cyc;
    s0 = starts;
    d0 = dones;
    rej = (x1 > x2) || (y1 > y2) || (x1 >= 10'd640) || (y1 >= 10'd480);
    x2c = (x2 > 10'd639) ? 10'd639 : x2;
    y2c = (y2 > 10'd479) ? 10'd479 : y2;
    exp_lines = 0;
    if (!rej) begin
      for (int l = int'(y1); l <= int'(y2c); l++) begin
        e.line = 10'(l);
        e.x1   = x1;
        e.x2   = x2c;
        e.bank = bank;
        exp_q.push_back(e);
        exp_lines++;
      end
    end
    done_q.push_back(rej);
    tick();
    i_cmd_valid = 1'b0;
    i_cmd_x1 = 10'($urandom);
    i_cmd_x2 = 10'($urandom);
    i_cmd_y1 = 10'($urandom);
    i_cmd_y2 = 10'($urandom);
    check("no_early_response", o_process_start | o_cmd_done, 0);
    if (spur) i_process_done = 1'b1;
    tick();
    check("first_latency", o_process_start | o_cmd_done, 1);
  endtask

  // Wait for the command's done pulse, optionally poking done during NEXT.
  task automatic finish(input bit spur);
    int n;
    n = 0;
    while (dones == d0 && n < 2000) begin
      tick();
      if (spur && last_fired) i_process_done = 1'b1;
      n++;
    end
    if (dones == d0) check("done_timeout", 0, 1);
    check("start_count", starts - s0, exp_lines);
  endtask

  initial begin
    i_reset_n = 1'b0;
    i_cmd_valid = 1'b0;
    i_cmd_x1 = '0;
    i_cmd_x2 = '0;
    i_cmd_y1 = '0;
    i_cmd_y2 = '0;
    i_buffer_bank = 1'b0;
    i_process_done = 1'b0;
    tick();
    tick();
    check("rst_done", o_cmd_done, 0);
    check("rst_busy", o_busy, 0);
    check("rst_start", o_process_start, 0);
    check("rst_line", o_line_address, 0);
    check("rst_x2", o_cmd_coord_x2, 0);
    i_reset_n = 1'b1;
    tick();
    check("rst_ready", o_cmd_ready, 1);

    // Normal three-line rectangle
    issue(10'd10, 10'd20, 10'd5, 10'd7, 1'b1, 1'b0);
    finish(1'b0);

    // Clipped at the right and bottom edges
    issue(10'd630, 10'd700, 10'd478, 10'd900, 1'b0, 1'b0);
    finish(1'b0);

    // Rejected commands
    issue(10'd50, 10'd40, 10'd0, 10'd0, 1'b0, 1'b0);
    finish(1'b0);
    issue(10'd0, 10'd10, 10'd480, 10'd490, 1'b1, 1'b0);
    finish(1'b0);
    issue(10'd640, 10'd700, 10'd0, 10'd0, 1'b0, 1'b0);
    finish(1'b0);

    // Single pixel, then a back-to-back command
    issue(10'd0, 10'd0, 10'd0, 10'd0, 1'b0, 1'b0);
    finish(1'b0);
    issue(10'd5, 10'd6, 10'd1, 10'd2, 1'b1, 1'b0);
    check("b2b_accept", acc_cyc, done_cyc + 1);
    finish(1'b0);

    // Bank toggling and spurious done pulses in CHECK and NEXT
    toggle_bank = 1;
    issue(10'd100, 10'd200, 10'd10, 10'd13, 1'b0, 1'b1);
    finish(1'b1);
    toggle_bank = 0;
    check("bank_hold", o_buffer_bank, 0);

    // Reset while waiting on the third of ten lines
    issue(10'd10, 10'd20, 10'd100, 10'd109, 1'b1, 1'b0);
    begin
      int n;
      n = 0;
      while (starts < s0 + 3 && n < 500) begin
        tick();
        n++;
      end
      check("reach_line3", starts - s0, 3);
    end
    tick();
    tick();
    i_reset_n = 1'b0;
    #1;
    check("mid_rst_done", o_cmd_done, 0);
    check("mid_rst_busy", o_busy, 0);
    check("mid_rst_start", o_process_start, 0);
    check("mid_rst_x1", o_cmd_coord_x1, 0);
    check("mid_rst_x2", o_cmd_coord_x2, 0);
    check("mid_rst_line", o_line_address, 0);
    check("mid_rst_bank", o_buffer_bank, 0);
    exp_q.delete();
    done_q.delete();
    cd = 0;
    d0 = dones;
    tick();
    tick();
    i_reset_n = 1'b1;
    tick();
    check("post_rst_ready", o_cmd_ready, 1);
    check("no_done_on_reset", dones, d0);
    issue(10'd3, 10'd9, 10'd20, 10'd21, 1'b1, 1'b0);
    finish(1'b0);

    check("exp_q_empty", exp_q.size(), 0);
    check("done_q_empty", done_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/renderer_rect_line_seq.md
Name: renderer_rect_line_seq

Overview:
Rectangle line sequencer that sits directly upstream of the rectangle-mix stage.
- Accepts one rectangle command (x1, x2, y1, y2) through a valid/ready handshake.
- Clips the command to the screen and drives the mix stage once per scanline: it presents the line address and X span, pulses process_start, then waits for process_done.
- Latches the target buffer bank per command so a bank swap mid-rectangle cannot tear it.

Parameters:
H_RES, 640, horizontal resolution in pixels; x coordinates >= H_RES are off-screen
V_RES, 480, vertical resolution in lines; y coordinates >= V_RES are off-screen

Ports:
i_master_clk  in  1  master clock; all logic on the rising edge
i_reset_n  in  1  asynchronous active-low reset
i_cmd_valid  in  1  command present
o_cmd_ready  out  1  sequencer can accept a command (high only in IDLE)
i_cmd_x1  in  10  left pixel, inclusive
i_cmd_x2  in  10  right pixel, inclusive
i_cmd_y1  in  10  top line, inclusive
i_cmd_y2  in  10  bottom line, inclusive
i_buffer_bank  in  1  current back-buffer bank; sampled at command accept
o_cmd_done  out  1  one-cycle pulse: command finished (rendered or rejected)
o_cmd_rejected  out  1  one-cycle pulse coincident with o_cmd_done when the command was discarded
o_busy  out  1  high from accept until the o_cmd_done cycle inclusive
o_cmd_coord_x1  out  10  clipped left X to mix stage
o_cmd_coord_x2  out  10  clipped right X to mix stage
o_line_address  out  10  current scanline to mix stage
o_buffer_bank  out  1  latched bank to mix stage
o_process_start  out  1  one-cycle start pulse to mix stage
i_process_done  in  1  one-cycle done pulse from mix stage

Behaviour:
- Reset (async, i_reset_n=0):
  - State is IDLE.
  - o_cmd_ready=1 once reset is released; o_cmd_done=o_cmd_rejected=o_busy=o_process_start=0.
  - Coordinate, line and bank outputs reset to 0.
  - Reset mid-command abandons the command without a done pulse. A pending mix-stage operation is the mix stage's own concern.
- States: IDLE, CHECK, START, WAIT, NEXT, DONE.
- IDLE:
  - o_cmd_ready=1.
  - On i_cmd_valid&&o_cmd_ready, latch x1, x2, y1, y2 and i_buffer_bank, then go to CHECK.
  - Command inputs are don't-care outside the accept cycle.
- CHECK (1 cycle):
  - Reject if x1>x2, y1>y2, x1>=H_RES or y1>=V_RES; on reject go to DONE with the rejected flag set.
  - Otherwise clamp x2 to min(x2, H_RES-1) and y2 to min(y2, V_RES-1), load line=y1, and go to START.
- START (1 cycle): o_process_start=1 (decoded from the registered state, glitch-free), then go to WAIT.
- WAIT:
  - Hold until i_process_done=1.
  - i_process_done seen in any other state is ignored.
- NEXT (1 cycle):
  - If line==y2_clamped, go to DONE.
  - Otherwise line<=line+1 and go to START.
  - The line counter never wraps, because y2_clamped<=V_RES-1.
- DONE (1 cycle): o_cmd_done=1, o_cmd_rejected=rejected flag, then go to IDLE.
- Timing:
  - First o_process_start is 2 cycles after the accept edge.
  - Gap from i_process_done to the next o_process_start is 2 cycles (NEXT, START), so the mix stage is back in IDLE when the next start arrives.
  - A rejected command gives o_cmd_done 2 cycles after accept.
  - A new command is accepted at the earliest 1 cycle after the o_cmd_done cycle.
- Output stability: o_cmd_coord_x1/x2, o_line_address and o_buffer_bank are registered. They are stable from the START cycle until i_process_done; line changes only in NEXT.
- Line count: exactly y2_clamped-y1+1 start pulses per accepted command. A single-line rectangle (y1==y2) gives one pulse.
- Bank: o_buffer_bank changes only on command accept; i_buffer_bank toggling mid-command has no effect.
- Only the outputs above are produced; the mix stage's own X handling is not duplicated.

Test Plan:
- Normal: x1=10, x2=20, y1=5, y2=7, bank=1; mix stage model answers done 8 cycles after each start -> 3 start pulses with line=5,6,7, x1=10, x2=20, bank=1; one o_cmd_done; o_cmd_rejected=0; first start 2 cycles after accept.
- Clipping: x1=630, x2=700, y1=478, y2=900 -> o_cmd_coord_x2=639; lines 478 and 479 only; 2 start pulses.
- Reject: (x1=50, x2=40), then (y1=480), then (x1=640, x2=700) -> each gives no start pulse, and o_cmd_done plus o_cmd_rejected 2 cycles after accept.
- Single pixel: x1=x2=0, y1=y2=0 -> one start, line=0, x1=x2=0; o_cmd_ready stays low until after done; back-to-back second command accepted 1 cycle after done.
- Bank and spurious done: toggle i_buffer_bank and pulse i_process_done during CHECK and NEXT -> o_buffer_bank constant, no skipped line, start count unchanged.
- Reset mid-command: assert i_reset_n=0 while in WAIT on line 3 of 10 -> all outputs reset immediately, no o_cmd_done; after release o_cmd_ready=1 and a fresh command runs normally.
